// File: rtl/delta_madd_engine.sv
// Scan engine over a DEPTH-entry saturating accumulator memory: MIN/MAX nonzero search, SUM, and
// multiply-free index-weighted sum (MADD). Define MULTIMAC_SAT_EN for saturating totals (default: wrap).
//
// state | meaning
// IDLE  | waiting; load/clear/run accepted
// SCAN  | walking memory one entry per cycle
// DONE  | result valid; load/clear/run accepted
module delta_madd_engine #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int MEM_W  = 6,
  parameter int OUT_W  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load,
  input  logic              run,
  input  logic [1:0]        insn,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] data,
  output logic [OUT_W-1:0]  out,
  output logic [IDX_W-1:0]  out_i,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = MEM_W + IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] M_MIN  = 2'b00;
  localparam logic [1:0] M_MAX  = 2'b01;
  localparam logic [1:0] M_MADD = 2'b10;
  localparam logic [1:0] M_SUM  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       mode;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] hit_idx;
  logic [CNT_W-1:0] count;
  logic [OUT_W:0]   total;
  logic [OUT_W-1:0] out_q;
  logic [MEM_W-1:0] mem [DEPTH];

  logic [MEM_W-1:0] mem_rd;
  logic [MEM_W:0]   ld_sum;
  logic [MEM_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt_next;
  logic [OUT_W:0]   total_next;
  logic [OUT_W-1:0] sum_out;

  always_comb begin
    mem_rd   = mem[idx];
    ld_sum   = {1'b0, mem[index]} + (MEM_W+1)'(data);
    ld_val   = ld_sum[MEM_W] ? '1 : ld_sum[MEM_W-1:0];
    cnt_next = count + CNT_W'(mem_rd);
  end

`ifdef MULTIMAC_SAT_EN
  localparam int SUM_W = ((OUT_W + 1 > CNT_W) ? OUT_W + 1 : CNT_W) + 1;
  localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'({OUT_W{1'b1}});

  logic [SUM_W-1:0] cnt_ext;
  logic [SUM_W-1:0] tot_sum;

  // Once total hits OUT_MAX it stays there, since count only adds non-negative values.
  always_comb begin
    cnt_ext    = SUM_W'(cnt_next);
    tot_sum    = SUM_W'(total) + cnt_ext;
    total_next = (tot_sum > OUT_MAX) ? (OUT_W+1)'(OUT_MAX) : (OUT_W+1)'(tot_sum);
    sum_out    = (cnt_ext > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : cnt_ext[OUT_W-1:0];
  end
`else
  assign total_next = {1'b0, OUT_W'(total + (OUT_W+1)'(cnt_next))};
  assign sum_out    = OUT_W'(cnt_next);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mode    <= M_MIN;
      idx     <= '0;
      hit_idx <= '0;
      count   <= '0;
      total   <= '0;
      out_q   <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (ena) begin
      case (state)
        ST_SCAN: begin
          case (mode)
            M_MIN: begin
              if (mem_rd != '0 || idx == IDX_LAST) begin
                out_q   <= OUT_W'(mem_rd);
                hit_idx <= idx;
                state   <= ST_DONE;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
            M_MAX: begin
              if (mem_rd != '0 || idx == '0) begin
                out_q   <= OUT_W'(mem_rd);
                hit_idx <= idx;
                state   <= ST_DONE;
              end else begin
                idx <= idx - IDX_W'(1);
              end
            end
            M_MADD: begin
              // Each entry's count is re-added once per lower index, giving sum(k*mem[k]).
              count <= cnt_next;
              total <= total_next;
              if (idx == IDX_W'(1)) begin
                out_q <= total_next[OUT_W-1:0];
                state <= ST_DONE;
              end else begin
                idx <= idx - IDX_W'(1);
              end
            end
            default: begin
              count <= cnt_next;
              if (idx == '0) begin
                out_q <= sum_out;
                state <= ST_DONE;
              end else begin
                idx <= idx - IDX_W'(1);
              end
            end
          endcase
        end
        default: begin
          if (load && run) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            state <= ST_IDLE;
          end else if (load) begin
            mem[index] <= ld_val;
            state      <= ST_IDLE;
          end else if (run) begin
            mode  <= insn;
            count <= '0;
            total <= '0;
            idx   <= (insn == M_MIN) ? '0 : IDX_LAST;
            state <= ST_SCAN;
          end
        end
      endcase
    end
  end

  assign out   = out_q;
  assign out_i = (state == ST_SCAN) ? idx : hit_idx;
  assign busy  = (state == ST_SCAN);
  assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_delta_madd_engine.sv
// Directed bench for delta_madd_engine: default instance plus an OUT_W=8 instance for overflow behaviour.
module tb_delta_madd_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       load;
  logic       run;
  logic [1:0] insn;
  logic [3:0] index;
  logic [3:0] data;

  logic [15:0] out;
  logic [3:0]  out_i;
  logic        busy;
  logic        done;
  logic [7:0]  out8;
  logic [3:0]  out_i8;
  logic        busy8;
  logic        done8;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  delta_madd_engine u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .run(run), .insn(insn),
    .index(index), .data(data), .out(out), .out_i(out_i), .busy(busy), .done(done)
  );

  delta_madd_engine #(.OUT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .run(run), .insn(insn),
    .index(index), .data(data), .out(out8), .out_i(out_i8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int i, input int d);
    load  = 1'b1;
    index = 4'(i);
    data  = 4'(d);
    step();
    load  = 1'b0;
  endtask

  task automatic do_clear();
    load = 1'b1;
    run  = 1'b1;
    step();
    load = 1'b0;
    run  = 1'b0;
  endtask

  task automatic start(input int mode);
    run  = 1'b1;
    insn = 2'(mode);
    step();
    run  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; load = 1'b0; run = 1'b0;
    insn = 2'd0; index = 4'd0; data = 4'd0;
    #3;
    chk("rst_out", int'(out), 0);
    chk("rst_out_i", int'(out_i), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    #19 rst_n = 1'b1;

    // MADD over (3,5),(10,2): 3*5 + 10*2 = 35
    step();
    do_load(3, 5);
    do_load(10, 2);
    start(2);
    chk("madd_busy", int'(busy), 1);
    wait_done(n);
    chk("madd_lat", n, 15);
    chk("madd_out", int'(out), 35);
    chk("madd_busy_low", int'(busy), 0);
    repeat (3) step();
    chk("madd_hold_out", int'(out), 35);
    chk("madd_hold_done", int'(done), 1);

    start(0);
    wait_done(n);
    chk("min_lat", n, 4);
    chk("min_idx", int'(out_i), 3);
    chk("min_out", int'(out), 5);

    start(1);
    wait_done(n);
    chk("max_lat", n, 6);
    chk("max_idx", int'(out_i), 10);
    chk("max_out", int'(out), 2);

    // load attempted during SCAN must be ignored
    start(3);
    do_load(5, 9);
    wait_done(n);
    chk("sum_lat", n + 1, 16);
    chk("sum_out", int'(out), 7);
    start(3);
    wait_done(n);
    chk("sum_rerun", int'(out), 7);

    // saturation of a single entry
    do_clear();
    chk("clear_keeps_out", int'(out), 7);
    chk("clear_idle", int'(done), 0);
    repeat (5) do_load(0, 15);
    start(3);
    wait_done(n);
    chk("sat_sum_lat", n, 16);
    chk("sat_sum_out", int'(out), 63);

    do_clear();
    start(0);
    wait_done(n);
    chk("min_miss_lat", n, 16);
    chk("min_miss_out", int'(out), 0);
    chk("min_miss_idx", int'(out_i), 15);

    // ena freeze mid-MADD
    do_load(3, 5);
    do_load(10, 2);
    start(2);
    repeat (4) step();
    ena = 1'b0;
    repeat (3) step();
    chk("freeze_busy", int'(busy), 1);
    chk("freeze_idx", int'(out_i), 11);
    ena = 1'b1;
    wait_done(n);
    chk("freeze_lat", n + 7, 18);
    chk("freeze_out", int'(out), 35);

    // async reset mid-SCAN
    start(3);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_out", int'(out), 0);
    #3 rst_n = 1'b1;
    step();
    start(3);
    wait_done(n);
    chk("arst_sum_lat", n, 16);
    chk("arst_sum_out", int'(out), 0);

    // overflow on OUT_W=8: 15*60 = 900
    repeat (4) do_load(15, 15);
    start(2);
    wait_done(n);
    chk("ovf_lat", n, 15);
    chk("ovf_done8", int'(done8), 1);
    chk("ovf_wide", int'(out), 900);
`ifdef MULTIMAC_SAT_EN
    chk("ovf_out8", int'(out8), 255);
`else
    chk("ovf_out8", int'(out8), 132);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
